// File: rtl/imul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imul_share_arbiter
// Purpose  : Round-robin share of one val/rdy multiplier between two
//            requesters, one transaction in flight, product routed to owner.
//            Optional grant counters under IMUL_SHARE_ARBITER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imul_share_arbiter #(
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32,
    parameter int p_cnt_nbits  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_req_nbits-1:0]  req0_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_req_nbits-1:0]  req1_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_resp_nbits-1:0] resp0_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,
    output logic                    mul_req_val,
    input  logic                    mul_req_rdy,
    output logic [p_req_nbits-1:0]  mul_req_msg,
    input  logic                    mul_resp_val,
    output logic                    mul_resp_rdy,
    input  logic [p_resp_nbits-1:0] mul_resp_msg
`ifdef IMUL_SHARE_ARBITER_CNT_EN
    ,
    output logic [p_cnt_nbits-1:0]  grant0_cnt,
    output logic [p_cnt_nbits-1:0]  grant1_cnt
`endif
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [p_req_nbits-1:0]  req_reg_q, req_reg_d;
    logic [p_resp_nbits-1:0] resp_reg_q, resp_reg_d;
    logic                    w_grant;
    logic                    w_any_val;

    // Contention flips the previous winner; a lone requester always wins.
    always_comb begin
        w_any_val = req0_val | req1_val;
        if (req0_val && !req1_val) begin
            w_grant = 1'b0;
        end else if (req1_val && !req0_val) begin
            w_grant = 1'b1;
        end else begin
            w_grant = ~last_grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= c_idle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            req_reg_q    <= '0;
            resp_reg_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            req_reg_q    <= req_reg_d;
            resp_reg_q   <= resp_reg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        req_reg_d    = req_reg_q;
        resp_reg_d   = resp_reg_q;
        case (state_q)
            c_idle: begin
                if (w_any_val) begin
                    state_d      = c_issue;
                    req_reg_d    = w_grant ? req1_msg : req0_msg;
                    owner_d      = w_grant;
                    last_grant_d = w_grant;
                end
            end
            c_issue: begin
                if (mul_req_rdy) begin
                    state_d = c_wait;
                end
            end
            c_wait: begin
                if (mul_resp_val) begin
                    resp_reg_d = mul_resp_msg;
                    state_d    = c_resp;
                end
            end
            c_resp: begin
                if (owner_q ? resp1_rdy : resp0_rdy) begin
                    state_d = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        mul_req_val  = 1'b0;
        mul_resp_rdy = 1'b0;
        case (state_q)
            c_idle: begin
                req0_rdy = w_any_val & ~w_grant;
                req1_rdy = w_any_val & w_grant;
            end
            c_issue: mul_req_val  = 1'b1;
            c_wait:  mul_resp_rdy = 1'b1;
            c_resp: begin
                resp0_val = ~owner_q;
                resp1_val = owner_q;
            end
            default: begin
                req0_rdy = 1'b0;
            end
        endcase
    end

    assign mul_req_msg = req_reg_q;
    assign resp0_msg   = resp_reg_q;
    assign resp1_msg   = resp_reg_q;

`ifdef IMUL_SHARE_ARBITER_CNT_EN
    localparam logic [p_cnt_nbits-1:0] c_cnt_one = p_cnt_nbits'(1);

    logic [p_cnt_nbits-1:0] grant0_cnt_q, grant0_cnt_d;
    logic [p_cnt_nbits-1:0] grant1_cnt_q, grant1_cnt_d;
    logic                   w_accept;

    assign w_accept = (state_q == c_idle) && w_any_val;

    always_comb begin
        grant0_cnt_d = grant0_cnt_q;
        grant1_cnt_d = grant1_cnt_q;
        if (w_accept && !w_grant) begin
            grant0_cnt_d = grant0_cnt_q + c_cnt_one;
        end
        if (w_accept && w_grant) begin
            grant1_cnt_d = grant1_cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else begin
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
`else
    logic [p_cnt_nbits-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule
`default_nettype wire
